// File: rtl/not_gate.sv
// rtl/not_gate.sv - bitwise inverter with registered copy and input toggle counter
module not_gate #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   input  logic             in_vld,
   output logic [WIDTH-1:0] out_q,
   output logic             out_q_vld,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] toggle_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] last_in;
   logic             toggled;

   assign out     = ~in;
   assign toggled = in_vld && (in != last_in);

   // out_q resets to the inverse of last_in's reset value so the two stay consistent
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= '1;
         out_q_vld <= 1'b0;
         last_in   <= '0;
      end else begin
         out_q_vld <= in_vld;
         if (in_vld) begin
            out_q   <= ~in;
            last_in <= in;
         end
      end
   end

   // clear wins over a same-edge toggle; the count saturates instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         toggle_cnt <= '0;
      end else if (cnt_clr) begin
         toggle_cnt <= '0;
      end else if (toggled && (toggle_cnt != CNT_MAX)) begin
         toggle_cnt <= toggle_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_not_gate.sv
// tb/tb_not_gate.sv - self-checking bench for not_gate
module tb_not_gate;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic        a_in = 1'b0, a_vld = 1'b0, a_clr = 1'b0;
   logic        a_out, a_q, a_qv;
   logic [15:0] a_cnt;

   logic [7:0]  b_in = 8'h00;
   logic        b_vld = 1'b0, b_clr = 1'b0;
   logic [7:0]  b_out, b_q;
   logic        b_qv;
   logic [15:0] b_cnt;

   logic        c_in = 1'b0, c_vld = 1'b0, c_clr = 1'b0;
   logic        c_out, c_q, c_qv;
   logic [1:0]  c_cnt;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   not_gate #(.WIDTH(1), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .in(a_in), .out(a_out), .in_vld(a_vld),
      .out_q(a_q), .out_q_vld(a_qv), .cnt_clr(a_clr), .toggle_cnt(a_cnt));

   not_gate #(.WIDTH(8), .CNT_W(16)) u_b (
      .clk(clk), .rst_n(rst_n), .in(b_in), .out(b_out), .in_vld(b_vld),
      .out_q(b_q), .out_q_vld(b_qv), .cnt_clr(b_clr), .toggle_cnt(b_cnt));

   not_gate #(.WIDTH(1), .CNT_W(2)) u_c (
      .clk(clk), .rst_n(rst_n), .in(c_in), .out(c_out), .in_vld(c_vld),
      .out_q(c_q), .out_q_vld(c_qv), .cnt_clr(c_clr), .toggle_cnt(c_cnt));

   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         logic exp;
         exp = (i % 2 == 0) ? 1'b1 : 1'b0;
         a_in = 1'(i % 2);
         #1;
         total++;
         if (a_out !== exp) $display("FAIL comb_in_reset[%0d]: got %b want %b", i, a_out, exp);
         else passed++;
         #4;
      end
      total++;
      if (a_q !== 1'b1 || a_qv !== 1'b0 || a_cnt !== 16'd0)
         $display("FAIL reset_a: q=%b qv=%b cnt=%0d want 1 0 0", a_q, a_qv, a_cnt);
      else passed++;
      total++;
      if (b_q !== 8'hFF || b_qv !== 1'b0 || b_cnt !== 16'd0 || c_cnt !== 2'd0)
         $display("FAIL reset_bc: bq=%h bqv=%b bcnt=%0d ccnt=%0d want ff 0 0 0", b_q, b_qv, b_cnt, c_cnt);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         logic exp;
         exp = (i % 2 == 0) ? 1'b1 : 1'b0;
         a_in = 1'(i % 2);
         #1;
         total++;
         if (a_out !== exp) $display("FAIL comb_run[%0d]: got %b want %b", i, a_out, exp);
         else passed++;
         #4;
      end
   endtask

   task automatic test_vector();
      logic [7:0] vals [3];
      logic [7:0] exps [3];
      vals = '{8'hA5, 8'h00, 8'hFF};
      exps = '{8'h5A, 8'hFF, 8'h00};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         b_in  = vals[i];
         b_vld = 1'b1;
         #1;
         total++;
         if (b_out !== exps[i]) $display("FAIL vec_out[%0d]: got %h want %h", i, b_out, exps[i]);
         else passed++;
         @(posedge clk);
         #1;
         total++;
         if (b_q !== exps[i] || b_qv !== 1'b1)
            $display("FAIL vec_q[%0d]: got %h/%b want %h/1", i, b_q, b_qv, exps[i]);
         else passed++;
      end
   endtask

   task automatic test_hold();
      // state entering: a never sampled, b saw A5,00,FF from 0 (three toggles)
      @(negedge clk);
      b_vld = 1'b0;
      a_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b_in = 8'($urandom);
         a_in = 1'($urandom_range(0, 1));
         #1;
         total++;
         if (b_out !== 8'(255 - int'(b_in))) $display("FAIL hold_out[%0d]: got %h want %h", i, b_out, 8'(255 - int'(b_in)));
         else passed++;
         @(posedge clk);
         #1;
         total++;
         if (b_q !== 8'h00 || b_qv !== 1'b0 || b_cnt !== 16'd3)
            $display("FAIL hold_b[%0d]: q=%h qv=%b cnt=%0d want 00 0 3", i, b_q, b_qv, b_cnt);
         else passed++;
         total++;
         if (a_q !== 1'b1 || a_qv !== 1'b0 || a_cnt !== 16'd0)
            $display("FAIL hold_a[%0d]: q=%b qv=%b cnt=%0d want 1 0 0", i, a_q, a_qv, a_cnt);
         else passed++;
      end
   endtask

   task automatic test_toggle_count();
      int seq [5];
      int exps [5];
      seq  = '{1, 0, 1, 1, 0};
      exps = '{1, 2, 3, 3, 4};
      @(negedge clk);
      a_in = 1'b0; a_vld = 1'b1; a_clr = 1'b1;
      @(negedge clk);
      a_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_in = 1'(seq[i]);
         @(posedge clk);
         #1;
         total++;
         if (int'(a_cnt) != exps[i]) $display("FAIL toggle_cnt[%0d]: got %0d want %0d", i, a_cnt, exps[i]);
         else passed++;
         @(negedge clk);
      end
      a_in = 1'b1; a_clr = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (a_cnt !== 16'd0) $display("FAIL clr_priority: got %0d want 0", a_cnt);
      else passed++;
      @(negedge clk);
      a_clr = 1'b0; a_in = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (a_cnt !== 16'd1) $display("FAIL after_clr: got %0d want 1", a_cnt);
      else passed++;
      @(negedge clk);
      a_vld = 1'b0;
   endtask

   task automatic test_saturation();
      @(negedge clk);
      c_in = 1'b0; c_vld = 1'b1; c_clr = 1'b1;
      @(negedge clk);
      c_clr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         int exp;
         exp = (i + 1 < 3) ? i + 1 : 3;
         c_in = 1'((i + 1) % 2);
         @(posedge clk);
         #1;
         total++;
         if (int'(c_cnt) != exp) $display("FAIL sat[%0d]: got %0d want %0d", i, c_cnt, exp);
         else passed++;
         @(negedge clk);
      end
      c_vld = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      a_in = 1'b0; a_vld = 1'b1; a_clr = 1'b1;
      @(negedge clk);
      a_clr = 1'b0; a_in = 1'b1;
      @(negedge clk);
      a_in = 1'b0;
      @(negedge clk);
      a_in = 1'b1;
      @(negedge clk);
      a_vld = 1'b0;
      total++;
      if (a_cnt !== 16'd3 || a_q !== 1'b0)
         $display("FAIL pre_reset: cnt=%0d q=%b want 3 0", a_cnt, a_q);
      else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (a_q !== 1'b1 || a_qv !== 1'b0 || a_cnt !== 16'd0)
         $display("FAIL async_reset: q=%b qv=%b cnt=%0d want 1 0 0", a_q, a_qv, a_cnt);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      a_in = 1'b1; a_vld = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (a_cnt !== 16'd1 || a_q !== 1'b0 || a_qv !== 1'b1)
         $display("FAIL post_reset: cnt=%0d q=%b qv=%b want 1 0 1", a_cnt, a_q, a_qv);
      else passed++;
      @(negedge clk);
      a_vld = 1'b0;
   endtask

   task automatic test_random();
      int a_last, a_m, a_mq, a_mqv;
      int b_last, b_m, b_mq, b_mqv;
      int c_last, c_m;
      @(negedge clk);
      a_in = 1'b0; a_vld = 1'b1; a_clr = 1'b1;
      b_in = 8'h00; b_vld = 1'b1; b_clr = 1'b1;
      c_in = 1'b0; c_vld = 1'b1; c_clr = 1'b1;
      a_last = 0; a_m = 0; a_mq = 1; a_mqv = 1;
      b_last = 0; b_m = 0; b_mq = 255; b_mqv = 1;
      c_last = 0; c_m = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         a_in = 1'($urandom_range(0, 1)); a_vld = 1'($urandom_range(0, 3) != 0);
         a_clr = 1'($urandom_range(0, 15) == 0);
         b_in = 8'($urandom_range(0, 3) == 0 ? b_last : int'($urandom_range(0, 255)));
         b_vld = 1'($urandom_range(0, 1)); b_clr = 1'($urandom_range(0, 15) == 0);
         c_in = 1'($urandom_range(0, 1)); c_vld = 1'($urandom_range(0, 3) != 0);
         c_clr = 1'($urandom_range(0, 31) == 0);
         #1;
         total++;
         if (int'(b_out) != 255 - int'(b_in) || int'(a_out) != 1 - int'(a_in))
            $display("FAIL rnd_out[%0d]: a=%b b=%h want %0d %0d", n, a_out, b_out, 1 - int'(a_in), 255 - int'(b_in));
         else passed++;
         // reference: counts accepted samples differing from the previous accepted one
         if (a_clr) a_m = 0;
         else if (a_vld && int'(a_in) != a_last) a_m = (a_m + 1 > 65535) ? 65535 : a_m + 1;
         if (a_vld) begin a_last = int'(a_in); a_mq = 1 - a_last; end
         a_mqv = int'(a_vld);
         if (b_clr) b_m = 0;
         else if (b_vld && int'(b_in) != b_last) b_m = (b_m + 1 > 65535) ? 65535 : b_m + 1;
         if (b_vld) begin b_last = int'(b_in); b_mq = 255 - b_last; end
         b_mqv = int'(b_vld);
         if (c_clr) c_m = 0;
         else if (c_vld && int'(c_in) != c_last) c_m = (c_m + 1 > 3) ? 3 : c_m + 1;
         if (c_vld) c_last = int'(c_in);
         @(posedge clk);
         #1;
         total++;
         if (int'(a_q) != a_mq || int'(a_qv) != a_mqv || int'(a_cnt) != a_m)
            $display("FAIL rnd_a[%0d]: q=%b qv=%b cnt=%0d want %0d %0d %0d", n, a_q, a_qv, a_cnt, a_mq, a_mqv, a_m);
         else passed++;
         total++;
         if (int'(b_q) != b_mq || int'(b_qv) != b_mqv || int'(b_cnt) != b_m)
            $display("FAIL rnd_b[%0d]: q=%h qv=%b cnt=%0d want %0h %0d %0d", n, b_q, b_qv, b_cnt, b_mq, b_mqv, b_m);
         else passed++;
         total++;
         if (int'(c_cnt) != c_m) $display("FAIL rnd_c[%0d]: cnt=%0d want %0d", n, c_cnt, c_m);
         else passed++;
      end
      @(negedge clk);
      a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
      a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_vector();
      test_hold();
      test_toggle_count();
      test_saturation();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, passed %0d of %0d", passed, total);
      $fatal(1, "watchdog");
   end

endmodule
